// File: rtl/up_dn_cnt_pkg.sv
// Shared definitions for the up/down counter family: mode encodings and the
// parameter range check used at elaboration.
package up_dn_cnt_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // True when the bounds fit the width and the largest step fits the range.
    function automatic bit range_ok(
        input int unsigned width,
        input longint unsigned min_val,
        input longint unsigned max_val,
        input int unsigned step_w
    );
        longint unsigned top;
        longint unsigned span;
        if (width == 0 || width > 62 || step_w == 0 || step_w > 62) return 1'b0;
        top = (64'd1 << width) - 64'd1;
        if (!(min_val < max_val) || max_val > top) return 1'b0;
        span = max_val - min_val + 64'd1;
        return (((64'd1 << step_w) - 64'd1) <= span);
    endfunction

endpackage

// File: rtl/up_dn_cnt_next.sv
// Combinational next-count and overflow/underflow computation for one
// up or down step, saturating or wrapping within [MIN_VAL, MAX_VAL].
module up_dn_cnt_next
    import up_dn_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 31,
    parameter int unsigned STEP_W  = 3
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  logic              wrap,
    output logic [WIDTH-1:0]  next_val,
    output logic              ovf,
    output logic              unf
);

    // One guard bit keeps every intermediate value from wrapping.
    localparam int unsigned EW = WIDTH + 1;
    localparam logic [EW-1:0] MIN_E = EW'(MIN_VAL);
    localparam logic [EW-1:0] MAX_E = EW'(MAX_VAL);
    localparam logic [EW-1:0] RNG_E = EW'(MAX_VAL - MIN_VAL + 1);

    logic [EW-1:0] count_e;
    logic [EW-1:0] step_e;
    logic [EW-1:0] res;

    assign count_e = EW'(count);
    assign step_e  = EW'(step);

    always_comb begin
        res = count_e;
        ovf = 1'b0;
        unf = 1'b0;
        if (up) begin
            res = count_e + step_e;
            if (res > MAX_E) begin
                ovf = 1'b1;
                res = (wrap == MODE_SAT) ? MAX_E : (res - RNG_E);
            end
        end else begin
            // count - step < MIN  <=>  count < MIN + step, with no negative term
            if (count_e < (MIN_E + step_e)) begin
                unf = 1'b1;
                res = (wrap == MODE_WRAP) ? (count_e + RNG_E - step_e) : MIN_E;
            end else begin
                res = count_e - step_e;
            end
        end
    end

    assign next_val = WIDTH'(res);

endmodule

// File: rtl/up_dn_counter_param.sv
// Parametrised up/down counter with programmable step, bounds, saturate/wrap
// mode and registered Ovf/Unf pulses. Optional sticky flags: UPDN_CNT_STICKY_EN.
module up_dn_counter_param
    import up_dn_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 31,
    parameter int unsigned STEP_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  IN,
    input  logic              Load,
    input  logic              Up,
    input  logic              Down,
    input  logic              Enable,
    input  logic [STEP_W-1:0] Step,
    input  logic              Wrap,
`ifdef UPDN_CNT_STICKY_EN
    input  logic              Clr_Flags,
    output logic              Ovf_Sticky,
    output logic              Unf_Sticky,
`endif
    output logic [WIDTH-1:0]  Counter,
    output logic              High,
    output logic              Low,
    output logic              Ovf,
    output logic              Unf
);

    localparam int unsigned EW = WIDTH + 1;
    localparam logic [EW-1:0]    MIN_E = EW'(MIN_VAL);
    localparam logic [EW-1:0]    MAX_E = EW'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    if (!range_ok(WIDTH, longint'(MIN_VAL), longint'(MAX_VAL), STEP_W)) begin : g_bad_cfg
        $error("up_dn_counter_param: illegal WIDTH/MIN_VAL/MAX_VAL/STEP_W combination");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic [WIDTH-1:0] step_val;
    logic             step_ovf;
    logic             step_unf;
    logic             count_op;
    logic [EW-1:0]    in_e;

    // Down takes priority over Up, so the step direction is simply !Down.
    up_dn_cnt_next #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_next (
        .count    (cnt_q),
        .step     (Step),
        .up       (~Down),
        .wrap     (Wrap),
        .next_val (step_val),
        .ovf      (step_ovf),
        .unf      (step_unf)
    );

    assign in_e     = EW'(IN);
    assign count_op = Enable && (Step != '0) && (Up || Down);

    // Load > Down > Up; loads are clamped into the legal range.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (Load) begin
            if ($signed(in_e) < $signed(MIN_E)) begin
                cnt_d = MIN_W;
            end else if (in_e > MAX_E) begin
                cnt_d = MAX_W;
            end else begin
                cnt_d = IN;
            end
        end else if (count_op) begin
            cnt_d = step_val;
            ovf_d = step_ovf;
            unf_d = step_unf;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= MIN_W;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

`ifdef UPDN_CNT_STICKY_EN
    logic ovf_sticky_q;
    logic unf_sticky_q;

    // A new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            if (ovf_d) begin
                ovf_sticky_q <= 1'b1;
            end else if (Clr_Flags) begin
                ovf_sticky_q <= 1'b0;
            end
            if (unf_d) begin
                unf_sticky_q <= 1'b1;
            end else if (Clr_Flags) begin
                unf_sticky_q <= 1'b0;
            end
        end
    end

    assign Ovf_Sticky = ovf_sticky_q;
    assign Unf_Sticky = unf_sticky_q;
`endif

    assign Counter = cnt_q;
    assign Ovf     = ovf_q;
    assign Unf     = unf_q;
    assign High    = (cnt_q == MAX_W);
    assign Low     = (cnt_q == MIN_W);

endmodule

// File: tb/tb_up_dn_counter_param.sv
// Bench for up_dn_counter_param: a default-range instance and a [2,20]
// instance share stimulus; a scoreboard model predicts every cycle.
module tb_up_dn_counter_param;

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
        bit high;
        bit low;
        bit so;
        bit su;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in_v = '0;
    logic       ld = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic       en = 1'b0;
    logic [2:0] stp = '0;
    logic       wr = 1'b0;
    logic       clr = 1'b0;

    logic [4:0] cnt [2];
    logic       hi  [2];
    logic       lo  [2];
    logic       ovf [2];
    logic       unf [2];
`ifdef UPDN_CNT_STICKY_EN
    logic       so  [2];
    logic       su  [2];
`endif

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    int mn [2] = '{0, 2};
    int mx [2] = '{31, 20};
    int mc [2];
    bit mo [2];
    bit mu [2];
    bit mso[2];
    bit msu[2];

    always #5 clk = ~clk;

    up_dn_counter_param u_def (
        .CLK(clk), .RST(rst), .IN(in_v), .Load(ld), .Up(up), .Down(dn),
        .Enable(en), .Step(stp), .Wrap(wr),
`ifdef UPDN_CNT_STICKY_EN
        .Clr_Flags(clr), .Ovf_Sticky(so[0]), .Unf_Sticky(su[0]),
`endif
        .Counter(cnt[0]), .High(hi[0]), .Low(lo[0]), .Ovf(ovf[0]), .Unf(unf[0])
    );

    up_dn_counter_param #(.WIDTH(5), .MIN_VAL(2), .MAX_VAL(20), .STEP_W(3)) u_rng (
        .CLK(clk), .RST(rst), .IN(in_v), .Load(ld), .Up(up), .Down(dn),
        .Enable(en), .Step(stp), .Wrap(wr),
`ifdef UPDN_CNT_STICKY_EN
        .Clr_Flags(clr), .Ovf_Sticky(so[1]), .Unf_Sticky(su[1]),
`endif
        .Counter(cnt[1]), .High(hi[1]), .Low(lo[1]), .Ovf(ovf[1]), .Unf(unf[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    // Reference model for instance d, evaluated on the inputs of this cycle.
    task automatic model(input int d, output exp_t e);
        int r;
        int v;
        int iv;
        r = mx[d] - mn[d] + 1;
        iv = int'(in_v);
        mo[d] = 1'b0;
        mu[d] = 1'b0;
        if (rst) begin
            mc[d] = mn[d];
            mso[d] = 1'b0;
            msu[d] = 1'b0;
        end else begin
            if (ld) begin
                mc[d] = (iv < mn[d]) ? mn[d] : ((iv > mx[d]) ? mx[d] : iv);
            end else if (en && stp != 0 && (up || dn)) begin
                if (dn) begin
                    v = mc[d] - int'(stp);
                    if (v < mn[d]) begin
                        mu[d] = 1'b1;
                        mc[d] = wr ? v + r : mn[d];
                    end else mc[d] = v;
                end else begin
                    v = mc[d] + int'(stp);
                    if (v > mx[d]) begin
                        mo[d] = 1'b1;
                        mc[d] = wr ? v - r : mx[d];
                    end else mc[d] = v;
                end
            end
            if (mo[d]) mso[d] = 1'b1; else if (clr) mso[d] = 1'b0;
            if (mu[d]) msu[d] = 1'b1; else if (clr) msu[d] = 1'b0;
        end
        e.cnt  = mc[d];
        e.ovf  = mo[d];
        e.unf  = mu[d];
        e.high = (mc[d] == mx[d]);
        e.low  = (mc[d] == mn[d]);
        e.so   = mso[d];
        e.su   = msu[d];
    endtask

    task automatic compare(input int d, input exp_t e);
        chk($sformatf("cnt%0d", d),  32'(cnt[d]), 32'(e.cnt));
        chk($sformatf("ovf%0d", d),  32'(ovf[d]), 32'(e.ovf));
        chk($sformatf("unf%0d", d),  32'(unf[d]), 32'(e.unf));
        chk($sformatf("high%0d", d), 32'(hi[d]),  32'(e.high));
        chk($sformatf("low%0d", d),  32'(lo[d]),  32'(e.low));
        chk($sformatf("excl%0d", d), 32'(ovf[d] & unf[d]), 32'(0));
`ifdef UPDN_CNT_STICKY_EN
        chk($sformatf("ovf_sticky%0d", d), 32'(so[d]), 32'(e.so));
        chk($sformatf("unf_sticky%0d", d), 32'(su[d]), 32'(e.su));
`endif
    endtask

    // Push predictions, clock once, then pop and compare away from the edge.
    task automatic cyc();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            model(d, e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e = sb.pop_front();
            compare(d, e);
        end
    endtask

    initial begin
        // reset state
        cyc();
        chk("rst_cnt0", 32'(cnt[0]), 32'd0);
        chk("rst_low1", 32'(lo[1]), 32'd1);
        chk("rst_high0", 32'(hi[0]), 32'd0);
        rst = 1'b0;

        // reset in the middle of a count
        ld = 1'b1; in_v = 5'd17; cyc();
        chk("load17", 32'(cnt[0]), 32'd17);
        ld = 1'b0; rst = 1'b1; cyc();
        chk("midrst_cnt", 32'(cnt[0]), 32'd0);
        chk("midrst_low", 32'(lo[0]), 32'd1);
        rst = 1'b0;

        // saturate up, repeated blocked request pulses again
        ld = 1'b1; in_v = 5'd29; cyc();
        ld = 1'b0; en = 1'b1; up = 1'b1; stp = 3'd5; wr = 1'b0; cyc();
        chk("sat_cnt", 32'(cnt[0]), 32'd31);
        chk("sat_ovf", 32'(ovf[0]), 32'd1);
        chk("sat_high", 32'(hi[0]), 32'd1);
        cyc();
        chk("sat_again_cnt", 32'(cnt[0]), 32'd31);
        chk("sat_again_ovf", 32'(ovf[0]), 32'd1);
        up = 1'b0; cyc();
        chk("ovf_one_cycle", 32'(ovf[0]), 32'd0);

        // wrap down in the [2,20] instance
        ld = 1'b1; in_v = 5'd4; cyc();
        ld = 1'b0; dn = 1'b1; stp = 3'd7; wr = 1'b1; cyc();
        chk("wrap_dn_cnt", 32'(cnt[1]), 32'd16);
        chk("wrap_dn_unf", 32'(unf[1]), 32'd1);
        chk("wrap_dn_cnt_def", 32'(cnt[0]), 32'd29);

        // Load over Down over Up
        ld = 1'b1; in_v = 5'd9; up = 1'b1; dn = 1'b1; cyc();
        chk("prio_load", 32'(cnt[0]), 32'd9);
        ld = 1'b0; stp = 3'd2; cyc();
        chk("prio_down", 32'(cnt[0]), 32'd7);
        chk("prio_noovf", 32'(ovf[0]), 32'd0);
        up = 1'b0; dn = 1'b0;

        // load clamp, Enable gating, zero step
        ld = 1'b1; in_v = 5'd25; cyc();
        chk("clamp_hi", 32'(cnt[1]), 32'd20);
        ld = 1'b0; en = 1'b0; dn = 1'b1; stp = 3'd3; cyc();
        chk("en_hold", 32'(cnt[1]), 32'd20);
        en = 1'b1; stp = 3'd0; cyc();
        chk("step0_hold", 32'(cnt[1]), 32'd20);
        chk("step0_nounf", 32'(unf[1]), 32'd0);
        ld = 1'b1; in_v = 5'd1; dn = 1'b0; cyc();
        chk("clamp_lo", 32'(cnt[1]), 32'd2);
        ld = 1'b0;

`ifdef UPDN_CNT_STICKY_EN
        // sticky set beats a same-cycle clear
        dn = 1'b1; stp = 3'd1; wr = 1'b0; cyc();
        chk("sticky_set", 32'(su[1]), 32'd1);
        clr = 1'b1; cyc();
        chk("sticky_set_wins", 32'(su[1]), 32'd1);
        dn = 1'b0; cyc();
        chk("sticky_clr", 32'(su[1]), 32'd0);
        clr = 1'b0;
`endif

        // randomised traffic including mid-count Wrap changes
        for (int i = 0; i < 120; i++) begin
            rst  = ($urandom_range(0, 24) == 0);
            ld   = ($urandom_range(0, 7) == 0);
            in_v = 5'($urandom_range(0, 31));
            up   = 1'($urandom_range(0, 1));
            dn   = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 5) != 0);
            stp  = 3'($urandom_range(0, 7));
            wr   = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 3) == 0);
            cyc();
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
